// File: rtl/bomb_fuse_ctrl.sv
// Multi-slot bomb manager: per-slot fuse countdown, chain-reaction trigger and timed blast.
// Runs on the frame clock; one edge per video frame.
module bomb_fuse_ctrl #(
    parameter int unsigned N_BOMBS      = 4,
    parameter int unsigned FUSE_FRAMES  = 180,
    parameter int unsigned BLAST_FRAMES = 30,
    parameter int unsigned GRID_W       = 5
) (
    input  logic                        frame_clk,
    input  logic                        Reset,
    input  logic                        place,
    input  logic [GRID_W-1:0]           place_x,
    input  logic [GRID_W-1:0]           place_y,
    input  logic [N_BOMBS-1:0]          chain_hit,
    output logic [N_BOMBS-1:0]          bomb_exist,
    output logic [N_BOMBS-1:0]          detonate,
    output logic [N_BOMBS-1:0]          blast_active,
    output logic [N_BOMBS*GRID_W-1:0]   bomb_x,
    output logic [N_BOMBS*GRID_W-1:0]   bomb_y,
    output logic                        full,
    output logic                        place_ok
);

    localparam int unsigned MAX_FRAMES = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BLAST = 2'd2
    } slot_state_t;

    slot_state_t        slot_state [N_BOMBS];
    logic [CNT_W-1:0]   cnt        [N_BOMBS];

    logic [N_BOMBS-1:0] grant_c;
    logic               dup_c;
    logic               accept_c;

    // Lowest IDLE slot wins; a request duplicating an ARMED slot's tile is refused.
    always_comb begin
        logic taken;
        taken   = 1'b0;
        grant_c = '0;
        dup_c   = 1'b0;
        for (int i = 0; i < N_BOMBS; i++) begin
            if (slot_state[i] == S_IDLE && !taken) begin
                grant_c[i] = 1'b1;
                taken      = 1'b1;
            end
            if (slot_state[i] == S_ARMED &&
                bomb_x[i*GRID_W +: GRID_W] == place_x &&
                bomb_y[i*GRID_W +: GRID_W] == place_y) begin
                dup_c = 1'b1;
            end
        end
    end

    assign accept_c = place && (|grant_c) && !dup_c;

    // Per-slot IDLE -> ARMED -> BLAST -> IDLE sequencing.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_BOMBS; i++) begin
                slot_state[i] <= S_IDLE;
                cnt[i]        <= '0;
            end
            bomb_x   <= '0;
            bomb_y   <= '0;
            detonate <= '0;
            place_ok <= 1'b0;
        end else begin
            place_ok <= accept_c;
            for (int i = 0; i < N_BOMBS; i++) begin
                detonate[i] <= 1'b0;
                case (slot_state[i])
                    S_IDLE: begin
                        if (accept_c && grant_c[i]) begin
                            slot_state[i]              <= S_ARMED;
                            cnt[i]                     <= CNT_W'(FUSE_FRAMES - 1);
                            bomb_x[i*GRID_W +: GRID_W] <= place_x;
                            bomb_y[i*GRID_W +: GRID_W] <= place_y;
                        end
                    end
                    S_ARMED: begin
                        if (chain_hit[i] || cnt[i] == '0) begin
                            slot_state[i] <= S_BLAST;
                            cnt[i]        <= CNT_W'(BLAST_FRAMES - 1);
                            detonate[i]   <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] - CNT_W'(1);
                        end
                    end
                    S_BLAST: begin
                        if (cnt[i] == '0) begin
                            slot_state[i]              <= S_IDLE;
                            bomb_x[i*GRID_W +: GRID_W] <= '0;
                            bomb_y[i*GRID_W +: GRID_W] <= '0;
                        end else begin
                            cnt[i] <= cnt[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                        slot_state[i] <= S_IDLE;
                        cnt[i]        <= '0;
                    end
                endcase
            end
        end
    end

    // Status flags decoded straight from the state flops.
    always_comb begin
        bomb_exist   = '0;
        blast_active = '0;
        for (int i = 0; i < N_BOMBS; i++) begin
            bomb_exist[i]   = (slot_state[i] == S_ARMED);
            blast_active[i] = (slot_state[i] == S_BLAST);
        end
    end

    assign full = &(bomb_exist | blast_active);

endmodule

// File: tb/tb_bomb_fuse_ctrl.sv
// Bench for bomb_fuse_ctrl: directed scenarios plus random traffic against a
// timestamp-based reference model of each slot's life cycle.
module tb_bomb_fuse_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned F  = 4;
    localparam int unsigned B  = 2;
    localparam int unsigned GW = 5;

    logic              frame_clk;
    logic              Reset;
    logic              place;
    logic [GW-1:0]     place_x;
    logic [GW-1:0]     place_y;
    logic [N-1:0]      chain_hit;
    logic [N-1:0]      bomb_exist;
    logic [N-1:0]      detonate;
    logic [N-1:0]      blast_active;
    logic [N*GW-1:0]   bomb_x;
    logic [N*GW-1:0]   bomb_y;
    logic              full;
    logic              place_ok;

    bomb_fuse_ctrl #(
        .N_BOMBS      (N),
        .FUSE_FRAMES  (F),
        .BLAST_FRAMES (B),
        .GRID_W       (GW)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .place        (place),
        .place_x      (place_x),
        .place_y      (place_y),
        .chain_hit    (chain_hit),
        .bomb_exist   (bomb_exist),
        .detonate     (detonate),
        .blast_active (blast_active),
        .bomb_x       (bomb_x),
        .bomb_y       (bomb_y),
        .full         (full),
        .place_ok     (place_ok)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: each slot remembers when it was placed and when it blew up.
    // After edge m a slot is ARMED for tp <= m < tb, in BLAST for tb <= m < tb+B.
    int  edge_no = 0;
    bit  m_act [N];
    int  m_tp  [N];
    int  m_tb  [N];
    int  m_x   [N];
    int  m_y   [N];
    bit  m_ok  = 1'b0;

    function automatic int slot_phase(int i, int m);
        if (!m_act[i])                          return 0;
        if (m >= m_tp[i] && m < m_tb[i])        return 1;
        if (m >= m_tb[i] && m < m_tb[i] + B)    return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_act[i] = 1'b0;
        m_ok = 1'b0;
    endtask

    task automatic model_edge(input bit p, input int px, input int py, input logic [N-1:0] ch);
        int  prior [N];
        int  slot;
        bit  dup;
        edge_no++;
        slot = -1;
        dup  = 1'b0;
        for (int i = 0; i < N; i++) prior[i] = slot_phase(i, edge_no - 1);
        for (int i = N - 1; i >= 0; i--) if (prior[i] == 0) slot = i;
        for (int i = 0; i < N; i++)
            if (prior[i] == 1 && m_x[i] == px && m_y[i] == py) dup = 1'b1;
        for (int i = 0; i < N; i++)
            if (prior[i] == 1 && ch[i] && m_tb[i] > edge_no) m_tb[i] = edge_no;
        m_ok = p && (slot >= 0) && !dup;
        if (m_ok) begin
            m_act[slot] = 1'b1;
            m_tp[slot]  = edge_no;
            m_tb[slot]  = edge_no + int'(F);
            m_x[slot]   = px;
            m_y[slot]   = py;
        end
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0]    e_exist, e_det, e_blast;
        logic [N*GW-1:0] e_x, e_y;
        int s;
        e_exist = '0; e_det = '0; e_blast = '0; e_x = '0; e_y = '0;
        for (int i = 0; i < N; i++) begin
            s = slot_phase(i, edge_no);
            e_exist[i] = (s == 1);
            e_blast[i] = (s == 2);
            e_det[i]   = (s == 2) && (m_tb[i] == edge_no);
            if (s != 0) begin
                e_x[i*GW +: GW] = GW'(m_x[i]);
                e_y[i*GW +: GW] = GW'(m_y[i]);
            end
        end
        check({tag, ".exist"},    64'(bomb_exist),   64'(e_exist));
        check({tag, ".det"},      64'(detonate),     64'(e_det));
        check({tag, ".blast"},    64'(blast_active), 64'(e_blast));
        check({tag, ".x"},        64'(bomb_x),       64'(e_x));
        check({tag, ".y"},        64'(bomb_y),       64'(e_y));
        check({tag, ".full"},     64'(full),         64'(&(e_exist | e_blast)));
        check({tag, ".place_ok"}, 64'(place_ok),     64'(m_ok));
    endtask

    // One frame: drive inputs, take the edge, update the model, compare 1 time unit later.
    task automatic step(input string tag, input bit p, input int px, input int py,
                        input logic [N-1:0] ch);
        place     = p;
        place_x   = GW'(px);
        place_y   = GW'(py);
        chain_hit = ch;
        @(posedge frame_clk);
        model_edge(p, px, py, ch);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) step(tag, 1'b0, 0, 0, '0);
    endtask

    // Mid-frame asynchronous reset pulse; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #3;
        Reset = 1'b1;
        #1;
        model_reset();
        check({tag, ".rst_exist"}, 64'(bomb_exist),   64'd0);
        check({tag, ".rst_blast"}, 64'(blast_active), 64'd0);
        check({tag, ".rst_xy"},    64'(bomb_x | bomb_y), 64'd0);
        check({tag, ".rst_misc"},  64'({detonate, full, place_ok}), 64'd0);
        Reset = 1'b0;
    endtask

    initial begin
        Reset     = 1'b1;
        place     = 1'b0;
        place_x   = '0;
        place_y   = '0;
        chain_hit = '0;
        repeat (2) @(posedge frame_clk);
        #1;
        model_reset();
        compare_all("reset");
        Reset = 1'b0;

        // 1: single bomb life cycle
        step("s1_place", 1'b1, 3, 4, '0);
        check("s1_ok", 64'(place_ok), 64'd1);
        idle("s1_run", 3);
        check("s1_armed_4th", 64'(bomb_exist), 64'h1);
        step("s1_det", 1'b0, 0, 0, '0);
        check("s1_detonate", 64'(detonate), 64'h1);
        idle("s1_blast", 1);
        check("s1_blast2", 64'(blast_active), 64'h1);
        idle("s1_end", 1);
        check("s1_idle_x", 64'(bomb_x[GW-1:0]), 64'd0);
        idle("s1_drain", 2);

        // 2: fill all slots, then overflow
        for (int k = 1; k <= 4; k++) step("s2_fill", 1'b1, k, 1, '0);
        check("s2_full", 64'(full), 64'd1);
        step("s2_over", 1'b1, 5, 1, '0);
        check("s2_over_ok", 64'(place_ok), 64'd0);
        idle("s2_drain", 10);

        // 3: duplicate rejected while armed, accepted once exploding
        step("s3_place", 1'b1, 7, 7, '0);
        step("s3_dup", 1'b1, 7, 7, '0);
        check("s3_dup_ok", 64'(place_ok), 64'd0);
        idle("s3_wait", 2);
        step("s3_blast", 1'b0, 0, 0, '0);
        check("s3_slot0_blast", 64'(blast_active), 64'h1);
        step("s3_reuse", 1'b1, 7, 7, '0);
        check("s3_reuse_ok", 64'(place_ok), 64'd1);
        check("s3_reuse_slot", 64'(bomb_exist), 64'h2);

        // 4: chain hit on armed slot 1, then on idle slot 2
        idle("s4_tick", 1);
        step("s4_chain", 1'b0, 0, 0, 4'b0010);
        check("s4_det", 64'(detonate), 64'h2);
        step("s4_chain_idle", 1'b0, 0, 0, 4'b0100);
        check("s4_exist", 64'(bomb_exist), 64'h0);
        check("s4_blast", 64'(blast_active), 64'h2);
        idle("s4_drain", 3);

        // 5: async reset with one slot exploding and one armed
        step("s5_p0", 1'b1, 1, 2, '0);
        step("s5_p1", 1'b1, 2, 2, '0);
        idle("s5_wait", 3);
        async_reset("s5");
        step("s5_after", 1'b1, 6, 6, '0);
        check("s5_slot0", 64'(bomb_exist), 64'h1);
        check("s5_x0", 64'(bomb_x[GW-1:0]), 64'd6);

        // 6: slot leaving BLAST is not allocatable on that edge
        idle("s6_clear", 7);
        for (int k = 0; k < 4; k++) step("s6_fill", 1'b1, 10 + k, 3, '0);
        idle("s6_wait", 2);
        step("s6_k", 1'b1, 9, 9, '0);
        check("s6_k_ok", 64'(place_ok), 64'd0);
        step("s6_k1", 1'b1, 9, 9, '0);
        check("s6_k1_ok", 64'(place_ok), 64'd1);
        check("s6_k1_slot0", 64'(bomb_exist[0]), 64'd1);

        // Random traffic on a small grid so duplicates and collisions are common
        for (int k = 0; k < 600; k++) begin
            logic [N-1:0] ch;
            ch = '0;
            for (int i = 0; i < N; i++) ch[i] = ($urandom_range(0, 7) == 0);
            step("rnd", ($urandom_range(0, 9) < 6), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ch);
            if ($urandom_range(0, 99) == 0) async_reset("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
